// File: rtl/data_pack.sv
// data_pack: packs a stream of IN_W-bit values into OUT_W-bit words, LSB-first.
// The first value of a word lands in bits [IN_W-1:0]. Packets are framed with
// sop/eop flags, and both sides use a valid/ready handshake.
//
// Optional feature macro: PACK_ERR_EN. When it is defined, the err_out port is
// added. err_out pulses for one cycle on a framing error. Framing recovery is
// the same whether or not the macro is defined.
//
// Ports:
//   clk        in   1      clock, all logic on posedge
//   rst_n      in   1      synchronous reset, active-low
//   ready_out  out  1      a value can be accepted this cycle
//   valid_in   in   1      value present (accepted when valid_in & ready_out)
//   data_in    in   IN_W   LSB-aligned input value
//   sop_in     in   1      first value of a packet
//   eop_in     in   1      last value of a packet
//   valid_out  out  1      data_out holds a word
//   data_out   out  OUT_W  packed word
//   sop_out    out  1      first word of a packet
//   eop_out    out  1      last word of a packet
//   ready_in   in   1      downstream takes the word when valid_out & ready_in
//   err_out    out  1      (PACK_ERR_EN only) one-cycle framing-error pulse
module data_pack #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready_out,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  input  logic             sop_in,
  input  logic             eop_in,
  output logic             valid_out,
  output logic [OUT_W-1:0] data_out,
  output logic             sop_out,
  output logic             eop_out,
  input  logic             ready_in
`ifdef PACK_ERR_EN
  ,
  output logic             err_out
`endif
);

  localparam int AW = OUT_W + IN_W - 1;      // widest bit count ever held
  localparam int CW = $clog2(OUT_W + IN_W);  // counts up to OUT_W+IN_W-1

  typedef enum logic [1:0] {IDLE, ACC, FLUSH} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_pend_sop;
  // Holds the value that carried an unexpected sop while its predecessor's
  // residue is flushed.
  logic [IN_W-1:0]  r_held;
  logic             r_held_eop;
  logic             r_held_vld;
  logic             r_valid_out;
  logic [OUT_W-1:0] r_data_out;
  logic             r_sop_out;
  logic             r_eop_out;

  logic             w_slot_free;
  logic             w_accept;
  logic             w_fresh;
  logic             w_err_sop;
  logic [AW-1:0]    w_src_acc;
  logic [CW-1:0]    w_src_cnt;
  logic             w_src_sop;
  logic [AW-1:0]    w_merged;
  logic [CW-1:0]    w_n;
  logic             w_word_done;
  logic [CW-1:0]    w_res_cnt;
  logic [AW-1:0]    w_residue;

  assign w_slot_free = !r_valid_out | ready_in;
  assign ready_out   = (r_state != FLUSH) & w_slot_free;
  assign w_accept    = valid_in & ready_out;

  // A sop starts from an empty accumulator. This applies in IDLE, and also in
  // ACC when nothing is held: the previous word has already left, so the new
  // sop itself marks the boundary.
  assign w_fresh   = sop_in & ((r_state == IDLE) | ((r_state == ACC) & (r_cnt == '0)));
  // A sop that arrives in ACC with residue held forces a flush of that residue.
  assign w_err_sop = sop_in & (r_state == ACC) & (r_cnt != '0);

  assign w_src_acc   = w_fresh ? '0 : r_acc;
  assign w_src_cnt   = w_fresh ? '0 : r_cnt;
  assign w_src_sop   = w_fresh ? 1'b1 : r_pend_sop;
  assign w_merged    = w_src_acc | (AW'(data_in) << w_src_cnt);
  assign w_n         = w_src_cnt + CW'(IN_W);
  assign w_word_done = (w_n >= CW'(OUT_W));
  assign w_res_cnt   = w_n - CW'(OUT_W);
  assign w_residue   = w_merged >> OUT_W;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_pend_sop  <= 1'b0;
      r_held      <= '0;
      r_held_eop  <= 1'b0;
      r_held_vld  <= 1'b0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_sop_out   <= 1'b0;
      r_eop_out   <= 1'b0;
    end else begin
      if (r_valid_out & ready_in)
        r_valid_out <= 1'b0;
      case (r_state)
        IDLE, ACC: begin
          if (w_accept) begin
            if (w_err_sop) begin
              r_held     <= data_in;
              r_held_eop <= eop_in;
              r_held_vld <= 1'b1;
              r_state    <= FLUSH;
            end else if ((r_state == IDLE) & !sop_in) begin
              // In IDLE, a value that arrives outside a packet is dropped.
            end else if (w_word_done) begin
              r_valid_out <= 1'b1;
              r_data_out  <= w_merged[OUT_W-1:0];
              r_sop_out   <= w_src_sop;
              r_eop_out   <= eop_in & (w_res_cnt == '0);
              r_pend_sop  <= 1'b0;
              if (eop_in & (w_res_cnt == '0)) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_state <= IDLE;
              end else begin
                r_acc   <= w_residue;
                r_cnt   <= w_res_cnt;
                r_state <= eop_in ? FLUSH : ACC;
              end
            end else if (eop_in) begin
              r_valid_out <= 1'b1;
              r_data_out  <= w_merged[OUT_W-1:0];
              r_sop_out   <= w_src_sop;
              r_eop_out   <= 1'b1;
              r_pend_sop  <= 1'b0;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= IDLE;
            end else begin
              r_acc      <= w_merged;
              r_cnt      <= w_n;
              r_pend_sop <= w_src_sop;
              r_state    <= ACC;
            end
          end
        end
        FLUSH: begin
          if (w_slot_free) begin
            // The residue is below OUT_W bits and its upper bits are already
            // zero, so the low slice is the padded word.
            r_valid_out <= 1'b1;
            r_data_out  <= r_acc[OUT_W-1:0];
            r_sop_out   <= r_pend_sop;
            r_eop_out   <= 1'b1;
            if (r_held_vld) begin
              // Restart with the value that broke the previous packet. If that
              // value also carried eop, it goes straight out through FLUSH.
              r_acc      <= AW'(r_held);
              r_cnt      <= CW'(IN_W);
              r_pend_sop <= 1'b1;
              r_held_vld <= 1'b0;
              r_state    <= r_held_eop ? FLUSH : ACC;
            end else begin
              r_acc      <= '0;
              r_cnt      <= '0;
              r_pend_sop <= 1'b0;
              r_state    <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign sop_out   = r_sop_out;
  assign eop_out   = r_eop_out;

`ifdef PACK_ERR_EN
  logic r_err;
  logic w_err_evt;

  assign w_err_evt = w_accept & ((sop_in & (r_state != IDLE)) |
                                 ((r_state == IDLE) & eop_in & !sop_in));

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_err <= 1'b0;
    else
      r_err <= w_err_evt;
  end

  assign err_out = r_err;
`endif

endmodule

// File: tb/tb_data_pack.sv
// Testbench for data_pack (IN_W=7, OUT_W=32). A table of input beats lists,
// for each beat, the words that beat is expected to produce. Those words are
// pushed into a scoreboard queue and compared as the DUT emits them.
// Hand-written sequences cover backpressure, back-to-back packets and reset.
module tb_data_pack;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  typedef struct {
    logic [6:0] data;
    logic       sop;
    logic       eop;
    logic       err;
    int         nexp;
    exp_t       e0;
    exp_t       e1;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        ready_out;
  logic        valid_in;
  logic [6:0]  data_in;
  logic        sop_in;
  logic        eop_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic        sop_out;
  logic        eop_out;
  logic        ready_in;
`ifdef PACK_ERR_EN
  logic        err_out;
`endif

  int   n_checks;
  int   n_errors;
  int   cyc;
  int   n_words;
  exp_t sb[$];
  int   out_cyc[$];
  vec_t tbl[22];

  data_pack #(.IN_W(7), .OUT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready_out (ready_out),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .sop_in    (sop_in),
    .eop_in    (eop_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .ready_in  (ready_in)
`ifdef PACK_ERR_EN
    ,
    .err_out   (err_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk_e(input logic [31:0] d, input logic s, input logic e);
    exp_t r;
    r.data = d;
    r.sop  = s;
    r.eop  = e;
    return r;
  endfunction

  function automatic vec_t mk_v(input logic [6:0] d, input logic s, input logic e,
                                input logic err, input int nexp, input exp_t e0, input exp_t e1);
    vec_t v;
    v.data = d;
    v.sop  = s;
    v.eop  = e;
    v.err  = err;
    v.nexp = nexp;
    v.e0   = e0;
    v.e1   = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Output monitor and scoreboard: compares every word taken by downstream.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && valid_out && ready_in) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_word actual data=%h sop=%b eop=%b required none",
                 data_out, sop_out, eop_out);
      end else begin
        e = sb.pop_front();
        if ({data_out, sop_out, eop_out} !== {e.data, e.sop, e.eop}) begin
          n_errors++;
          $display("FAIL word actual data=%h sop=%b eop=%b required data=%h sop=%b eop=%b",
                   data_out, sop_out, eop_out, e.data, e.sop, e.eop);
        end else begin
          $display("word %0d data=%h sop=%b eop=%b", n_words, data_out, sop_out, eop_out);
        end
      end
      n_words++;
      out_cyc.push_back(cyc);
    end
  end

  // Drive one beat and hold it until it is accepted (bounded wait).
  task automatic send(input logic [6:0] d, input logic s, input logic e);
    int t;
    t = 0;
    valid_in = 1'b1;
    data_in  = d;
    sop_in   = s;
    eop_in   = e;
    @(negedge clk);
    while (!ready_out && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!ready_out) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout actual ready_out=0 required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      t++;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #1;
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  // Independent packing model: a bit queue consumed 32 bits at a time.
  task automatic push_model(input logic [6:0] vals[32], input int n);
    logic        bits[$];
    logic [6:0]  v;
    logic [31:0] word;
    int          w;
    w = 0;
    for (int i = 0; i < n; i++) begin
      v = vals[i];
      for (int b = 0; b < 7; b++) bits.push_back(v[b]);
    end
    while (bits.size() > 0) begin
      word = '0;
      for (int b = 0; b < 32; b++)
        if (bits.size() > 0) word[b] = bits.pop_front();
      sb.push_back(mk_e(word, w == 0, bits.size() == 0));
      w++;
    end
  endtask

  initial begin
    exp_t        nx;
    logic [6:0]  vals[32];
    logic [31:0] held_data;
    logic        held_sop;
    logic        held_eop;
    int          idx;
    int          t;
    time         t0;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    n_words  = 0;
    nx       = mk_e(32'h0, 1'b0, 1'b0);

    // Packing of 0..4 then 5..8 ending in eop
    tbl[0]  = mk_v(7'h00, 1, 0, 0, 0, nx, nx);
    tbl[1]  = mk_v(7'h01, 0, 0, 0, 0, nx, nx);
    tbl[2]  = mk_v(7'h02, 0, 0, 0, 0, nx, nx);
    tbl[3]  = mk_v(7'h03, 0, 0, 0, 0, nx, nx);
    tbl[4]  = mk_v(7'h04, 0, 0, 0, 1, mk_e(32'h4060_8080, 1, 0), nx);
    tbl[5]  = mk_v(7'h05, 0, 0, 0, 0, nx, nx);
    tbl[6]  = mk_v(7'h06, 0, 0, 0, 0, nx, nx);
    tbl[7]  = mk_v(7'h07, 0, 0, 0, 0, nx, nx);
    tbl[8]  = mk_v(7'h08, 0, 1, 0, 1, mk_e(32'h080E_1828, 0, 1), nx);
    // Five 7'h7F values: one full word, then a 3-bit residue flushed
    tbl[9]  = mk_v(7'h7F, 1, 0, 0, 0, nx, nx);
    tbl[10] = mk_v(7'h7F, 0, 0, 0, 0, nx, nx);
    tbl[11] = mk_v(7'h7F, 0, 0, 0, 0, nx, nx);
    tbl[12] = mk_v(7'h7F, 0, 0, 0, 0, nx, nx);
    tbl[13] = mk_v(7'h7F, 0, 1, 0, 2, mk_e(32'hFFFF_FFFF, 1, 0), mk_e(32'h0000_0007, 0, 1));
    // Values outside a packet are dropped; a stray eop is flagged
    tbl[14] = mk_v(7'h05, 0, 0, 0, 0, nx, nx);
    tbl[15] = mk_v(7'h05, 0, 0, 0, 0, nx, nx);
    tbl[16] = mk_v(7'h05, 0, 1, 1, 0, nx, nx);
    tbl[17] = mk_v(7'h55, 1, 1, 0, 1, mk_e(32'h0000_0055, 1, 1), nx);
    // A sop in the middle of a packet forces eop on the residue and restarts
    tbl[18] = mk_v(7'h7F, 1, 0, 0, 0, nx, nx);
    tbl[19] = mk_v(7'h7F, 0, 0, 0, 0, nx, nx);
    tbl[20] = mk_v(7'h11, 1, 0, 1, 1, mk_e(32'h0000_3FFF, 1, 1), nx);
    tbl[21] = mk_v(7'h22, 0, 1, 0, 1, mk_e(32'h0000_1111, 1, 1), nx);

    // Reset state
    rst_n    = 1'b0;
    ready_in = 1'b1;
    data_in  = '0;
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_sop_eop", 64'({sop_out, eop_out}), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_ready_out", 64'(ready_out), 64'd1);
`ifdef PACK_ERR_EN
    chk("rst_err_out", 64'(err_out), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors, applied back-to-back
    for (int i = 0; i < 22; i++) begin
      if (tbl[i].nexp > 0) sb.push_back(tbl[i].e0);
      if (tbl[i].nexp > 1) sb.push_back(tbl[i].e1);
      send(tbl[i].data, tbl[i].sop, tbl[i].eop);
`ifdef PACK_ERR_EN
      chk($sformatf("err_out_beat%0d", i), 64'(err_out), 64'(tbl[i].err));
`endif
    end
    idle_in();
    drain("table_drain");

    // 32 x 7'h7F: seven all-ones words, values accepted every cycle
    for (int w = 0; w < 7; w++) sb.push_back(mk_e(32'hFFFF_FFFF, w == 0, w == 6));
    t0 = $time;
    for (int i = 0; i < 32; i++) send(7'h7F, i == 0, i == 31);
    chk("full_input_gapless", 64'(($time - t0) / 10), 64'd32);
    idle_in();
    drain("full_drain");

    // Backpressure: stall downstream for 4+ cycles mid-packet
    for (int i = 0; i < 20; i++) vals[i] = 7'((i * 5 + 3) & 7'h7F);
    push_model(vals, 20);
    fork
      begin
        for (int i = 0; i < 20; i++) send(vals[i], i == 0, i == 19);
        idle_in();
      end
      begin
        t = 0;
        @(negedge clk);
        while (!valid_out && t < 100) begin
          t++;
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        ready_in = 1'b0;
        t = 0;
        @(negedge clk);
        while (!valid_out && t < 100) begin
          t++;
          @(negedge clk);
        end
        chk("stall_valid", 64'(valid_out), 64'd1);
        held_data = data_out;
        held_sop  = sop_out;
        held_eop  = eop_out;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_data_stable", 64'({data_out, sop_out, eop_out, valid_out}),
              64'({held_data, held_sop, held_eop, 1'b1}));
          chk("stall_ready_out", 64'(ready_out), 64'd0);
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
      end
    join
    drain("stall_drain");

    // Back-to-back packets: B's sop immediately after A's eop
    idx = out_cyc.size();
    sb.push_back(mk_e(32'h0000_0101, 1, 1));
    sb.push_back(mk_e(32'h0000_0003, 1, 1));
    send(7'h01, 1, 0);
    send(7'h02, 0, 1);
    send(7'h03, 1, 1);
    idle_in();
    drain("b2b_drain");
    if (out_cyc.size() >= idx + 2)
      chk("b2b_no_gap", 64'(out_cyc[idx+1] - out_cyc[idx]), 64'd1);
    else
      chk("b2b_word_count", 64'(out_cyc.size() - idx), 64'd2);

    // Reset mid-packet while a word is pending: everything is dropped
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) send(7'h7F, i == 0, 1'b0);
    idle_in();
    @(posedge clk);
    #1;
    chk("pre_rst_pending", 64'(valid_out), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_outputs", 64'({valid_out, sop_out, eop_out, data_out}), 64'd0);
    rst_n    = 1'b1;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(mk_e(32'h0000_0001, 1, 1));
    send(7'h05, 0, 0);
    send(7'h01, 1, 0);
    send(7'h00, 0, 1);
    idle_in();
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
